switch_debouncer: RTL
=====================

Name: switch_debouncer

Overview:
- Conditions a raw, bouncing wall-switch or push-button input before it reaches the d_ff storage stage.
- Synchronises the input and filters it with a stability counter.
- Outputs a clean level (drives d_ff's d), one-cycle rise/fall strobes, and a registered toggle for press-to-toggle loads such as lights and relays.
- All logic is in the clk domain.

Parameters:
STABLE_CYCLES, 1000, consecutive synchronised samples at the new level needed to accept a change; minimum 2.
CNT_W, 16, stability counter width; 2**CNT_W >= STABLE_CYCLES is required.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
btn_in  input  1  raw asynchronous switch level; 1 = pressed.
en  input  1  filter enable; 0 freezes the accepted level.
db_out  output  1  debounced level; registered.
rise_pulse  output  1  one-cycle strobe when db_out goes 0->1.
fall_pulse  output  1  one-cycle strobe when db_out goes 1->0.
toggle_q  output  1  inverts on every rise_pulse.
busy  output  1  1 while a candidate change is being qualified.

Behaviour:
- Reset: asynchronous, active-high; one clock (clk), no other clock domain.
- While rst=1, all of the following are 0: sync flops s1/s2, counter, db_out, rise_pulse, fall_pulse, toggle_q, busy.
- While rst=1, the state is IDLE_LOW. Reset applied mid-qualification aborts it with no pulse.
- Synchroniser: two flops, btn_in -> s1 -> s2. Only s2 is used downstream.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
- IDLE_LOW: if en=1 and s2=1, go to WAIT_HIGH with cnt=0.
- WAIT_HIGH:
  - s2=0: return to IDLE_LOW, cnt=0 (a bounce restarts qualification).
  - s2=1 and cnt==STABLE_CYCLES-1: go to IDLE_HIGH; db_out<=1, rise_pulse<=1, toggle_q<=~toggle_q.
  - Otherwise: cnt<=cnt+1.
- IDLE_HIGH and WAIT_LOW: mirror of IDLE_LOW and WAIT_HIGH with the levels inverted. Acceptance sets db_out<=0 and fall_pulse<=1; toggle_q is unchanged.
- en=0 in any WAIT state: return to the corresponding IDLE state, cnt=0, no pulse. While en=0 the FSM stays idle; the synchroniser keeps running.
- Latency: the first rising edge sampling btn_in=1 counts as edge 1. db_out and rise_pulse become 1 after edge STABLE_CYCLES+3, provided btn_in and en are stable throughout. Falling edges have the same latency.
- rise_pulse and fall_pulse:
  - Each is high for exactly one cycle.
  - They are never high together, and each is never high on consecutive cycles.
  - The minimum spacing between a rise and the following fall is STABLE_CYCLES+1 cycles.
- busy = 1 exactly in WAIT_HIGH and WAIT_LOW; registered with the state.
- Counter never exceeds STABLE_CYCLES-1 and never wraps.
- btn_in held at 1 through reset release: qualified normally afterwards, producing one rise_pulse. The post-reset level is always treated as released.
- No combinational path from btn_in or en to any output.

Test Plan (STABLE_CYCLES=4, CNT_W=3, clk period 20 ns):
- Reset/idle:
  - Stimulus: rst=1 for 35 ns with btn_in toggling.
  - Response: all outputs 0 throughout. After release with btn_in=0 held for 200 ns, outputs stay 0.
- Clean press:
  - Stimulus: btn_in 0->1 before edge N, en=1.
  - Response: busy=1 from edge N+2. After edge N+6, db_out=1, rise_pulse=1 for one cycle, toggle_q=1, busy=0.
- Bounce rejection:
  - Stimulus: btn_in pattern 1,0,1,0 for 1 cycle each, then held 1.
  - Response: no pulse during the bounce. A single rise_pulse after edge STABLE_CYCLES+3 counted from the final 0->1 sample.
- Release and second press:
  - Stimulus: release held for 10 cycles, then press held.
  - Response: one fall_pulse with db_out=0 and toggle_q still 1. The second press gives a rise_pulse and toggle_q=0.
- Enable gating:
  - Stimulus: press held, en dropped to 0 at the second WAIT_HIGH cycle for 3 cycles, then back to 1.
  - Response: busy returns to 0 and cnt clears. db_out rises STABLE_CYCLES+1 edges after en returns to 1.
- Reset mid-operation:
  - Stimulus: rst pulsed for 5 ns while busy=1, btn_in held 1.
  - Response: outputs go to 0 asynchronously. A fresh qualification then produces exactly one rise_pulse at STABLE_CYCLES+3 edges after release.

Source files
------------

// File: rtl/switch_debouncer.sv
// Switch/button conditioner: two-flop synchroniser, stability-count filter,
// debounced level, one-cycle rise/fall strobes and a press-to-toggle output.
module switch_debouncer #(
   parameter int unsigned STABLE_CYCLES = 1000,
   parameter int unsigned CNT_W         = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   input  logic en,
   output logic db_out,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic toggle_q,
   output logic busy
);

   // Last count value in a WAIT state before the new level is accepted.
   localparam logic [CNT_W-1:0] cnt_last = CNT_W'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      IDLE_HIGH = 2'd2,
      WAIT_LOW  = 2'd3
   } state_t;

   state_t           state;
   logic             s1;
   logic             s2;
   logic [CNT_W-1:0] cnt;

   // Two-flop synchroniser for the asynchronous switch level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= btn_in;
         s2 <= s1;
      end
   end

   // Qualification FSM with stability counter and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE_LOW;
         cnt        <= '0;
         db_out     <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         toggle_q   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         case (state)
            IDLE_LOW: begin
               if (en && s2) begin
                  state <= WAIT_HIGH;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            WAIT_HIGH: begin
               // A disable or a bounce back to low restarts qualification.
               if (!en || !s2) begin
                  state <= IDLE_LOW;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (cnt == cnt_last) begin
                  state      <= IDLE_HIGH;
                  cnt        <= '0;
                  busy       <= 1'b0;
                  db_out     <= 1'b1;
                  rise_pulse <= 1'b1;
                  toggle_q   <= ~toggle_q;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            IDLE_HIGH: begin
               if (en && !s2) begin
                  state <= WAIT_LOW;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            WAIT_LOW: begin
               if (!en || s2) begin
                  state <= IDLE_HIGH;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (cnt == cnt_last) begin
                  state      <= IDLE_LOW;
                  cnt        <= '0;
                  busy       <= 1'b0;
                  db_out     <= 1'b0;
                  fall_pulse <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE_LOW;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
